// File: rtl/fx3_dp_sched_if.sv
// Handshake bundle between the FX3 data-port scheduler and the per-port output FSMs.
// master = scheduler side, slave = port FSMs / GPIF pin mux side.
interface fx3_dp_sched_if #(
  parameter int N_PORTS = 3
);
  logic               en_i;
  logic [N_PORTS-1:0] req_i;
  logic [N_PORTS-1:0] done_i;
  logic [N_PORTS-1:0] strt_o;
  logic [1:0]         fifo_addr_o;
  logic [1:0]         sel_o;
  logic               bus_own_o;
  logic               busy_o;
  logic               wdog_err_o;
  logic [15:0]        xfer_cnt_o;

  modport master (
    input  en_i, req_i, done_i,
    output strt_o, fifo_addr_o, sel_o, bus_own_o, busy_o, wdog_err_o, xfer_cnt_o
  );

  modport slave (
    output en_i, req_i, done_i,
    input  strt_o, fifo_addr_o, sel_o, bus_own_o, busy_o, wdog_err_o, xfer_cnt_o
  );
endinterface

// File: rtl/fx3_dp_sched.sv
// Round-robin owner of the FX3 GPIF-II slave-FIFO bus for up to four output data ports.
// Grants one port at a time: address setup, start pulse, wait for done (with watchdog), release.
module fx3_dp_sched #(
  parameter int          N_PORTS   = 3,
  parameter logic [1:0]  ADDR_BASE = 2'd1,
  parameter logic [3:0]  TURN_CYC  = 4'd2,
  parameter logic [15:0] WDOG_CYC  = 16'd4096,
  parameter logic [15:0] CNT_INIT  = 16'd0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  fx3_dp_sched_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ADDR_SETUP = 3'd1,
    START      = 3'd2,
    WAIT_DONE  = 3'd3,
    RELEASE    = 3'd4
  } state_t;

  localparam logic [3:0]  SETUP_LAST = TURN_CYC - 4'd1;
  localparam logic [15:0] WDOG_LAST  = WDOG_CYC - 16'd1;
  localparam logic [1:0]  PORT_LAST  = 2'(N_PORTS - 1);

  state_t      state;
  logic [1:0]  rr_ptr;
  logic [3:0]  setup_cnt;
  logic [15:0] wdog_cnt;
  logic        pick_vld;
  logic [1:0]  pick_idx;
  logic        gnt_done;

  // First requesting port at or after ptr, wrapping modulo N_PORTS; MSB flags "found".
  function automatic logic [2:0] rr_pick(input logic [N_PORTS-1:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      idx = 2'((int'(ptr) + i) % N_PORTS);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == PORT_LAST) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [N_PORTS-1:0] onehot(input logic [1:0] p);
    logic [N_PORTS-1:0] v;
    v = '0;
    v[p] = 1'b1;
    return v;
  endfunction

  always_comb begin
    {pick_vld, pick_idx} = rr_pick(bus.req_i, rr_ptr);
    gnt_done             = bus.done_i[bus.sel_o];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= IDLE;
      rr_ptr          <= 2'd0;
      setup_cnt       <= 4'd0;
      wdog_cnt        <= 16'd0;
      bus.strt_o      <= '0;
      bus.fifo_addr_o <= ADDR_BASE;
      bus.sel_o       <= 2'd0;
      bus.bus_own_o   <= 1'b0;
      bus.busy_o      <= 1'b0;
      bus.wdog_err_o  <= 1'b0;
      bus.xfer_cnt_o  <= CNT_INIT;
    end else begin
      bus.strt_o <= '0;
      case (state)
        IDLE: begin
          if (bus.en_i && pick_vld) begin
            bus.sel_o       <= pick_idx;
            bus.fifo_addr_o <= ADDR_BASE + pick_idx;
            bus.bus_own_o   <= 1'b1;
            bus.busy_o      <= 1'b1;
            setup_cnt       <= 4'd0;
            state           <= ADDR_SETUP;
          end
        end
        // Address is already on the pins; hold it TURN_CYC cycles before START.
        ADDR_SETUP: begin
          if (setup_cnt == SETUP_LAST) state <= START;
          else                          setup_cnt <= setup_cnt + 4'd1;
        end
        START: begin
          bus.strt_o <= onehot(bus.sel_o);
          wdog_cnt   <= 16'd0;
          state      <= WAIT_DONE;
        end
        // A done arriving on the watchdog's last cycle wins over the abort.
        WAIT_DONE: begin
          if (gnt_done) begin
            bus.xfer_cnt_o <= bus.xfer_cnt_o + 16'd1;
            rr_ptr         <= next_port(bus.sel_o);
            bus.bus_own_o  <= 1'b0;
            state          <= RELEASE;
          end else if (wdog_cnt == WDOG_LAST) begin
            bus.wdog_err_o <= 1'b1;
            rr_ptr         <= next_port(bus.sel_o);
            bus.bus_own_o  <= 1'b0;
            state          <= RELEASE;
          end else begin
            wdog_cnt <= wdog_cnt + 16'd1;
          end
        end
        RELEASE: begin
          bus.busy_o <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          bus.busy_o    <= 1'b0;
          bus.bus_own_o <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
